// File: rtl/freq_meas_pkg.sv
// Shared constants for the frequency conversion path: FSM encoding,
// datapath widths and the saturation value reported on overflow.
package freq_meas_pkg;

  localparam int NUM_W  = 64;
  localparam int DEN_W  = 32;
  localparam int ITER_N = 64;
  localparam int CNT_W  = $clog2(ITER_N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [DEN_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/seq_udiv64.sv
// Unsigned restoring 64/32 divider, one quotient bit per clock, MSB first.
// done_o is high during the cycle whose rising edge retires the last bit.
module seq_udiv64
  import freq_meas_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o,
  output logic             dz_o
);

  logic [NUM_W-1:0] num_q;
  logic [DEN_W-1:0] den_q;
  logic [NUM_W:0]   rem_q;
  logic [NUM_W-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             dz_q;

  logic [NUM_W:0]   rem_shift;
  logic [NUM_W:0]   den_ext;
  logic [NUM_W:0]   rem_next;
  logic             take;

  // A set top remainder bit would make the shifted value exceed any divisor.
  always_comb begin
    rem_shift = {rem_q[NUM_W-1:0], num_q[cnt_q]};
    den_ext   = {{(NUM_W+1-DEN_W){1'b0}}, den_q};
    take      = rem_q[NUM_W] | (rem_shift >= den_ext);
    rem_next  = take ? (rem_shift - den_ext) : rem_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      dz_q  <= 1'b0;
    end else if (start_i) begin
      num_q <= num_i;
      den_q <= den_i;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= CNT_W'(ITER_N - 1);
      run_q <= 1'b1;
      dz_q  <= (den_i == '0);
    end else if (run_q) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[NUM_W-2:0], take};
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign quo_o  = quo_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/freq_calc.sv
// Turns a (fx_cnt, gate_cnt) pair into freq_hz = fx_cnt * CLK_SYS_HZ / gate_cnt.
// Define FREQ_CALC_ROUND_EN for round-to-nearest; otherwise the result truncates.
module freq_calc
  import freq_meas_pkg::*;
#(
  parameter logic [31:0] CLK_SYS_HZ = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fx_cnt,
  input  logic [31:0] gate_cnt,
  input  logic        data_ready,
  output logic [31:0] freq_hz,
  output logic        freq_valid,
  output logic        busy,
  output logic        err,
  output logic        overrun
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      fx_q, fx_d;
  logic [31:0]      gate_q, gate_d;
  logic [31:0]      freq_q, freq_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;

  logic [NUM_W-1:0] product;
  logic [NUM_W-1:0] numer;
  logic             div_start;
  logic             div_done;
  logic [NUM_W-1:0] quo;
  logic             div_zero;

  assign product = NUM_W'(fx_q) * NUM_W'(CLK_SYS_HZ);

`ifdef FREQ_CALC_ROUND_EN
  // Half the divisor biases the quotient so halves round up.
  assign numer = product + NUM_W'(gate_q >> 1);
`else
  assign numer = product;
`endif

  assign div_start = (state_q == ST_MUL);

  seq_udiv64 u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (div_start),
    .num_i   (numer),
    .den_i   (gate_q),
    .done_o  (div_done),
    .quo_o   (quo),
    .dz_o    (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    fx_d      = fx_q;
    gate_d    = gate_q;
    freq_d    = freq_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_ready) begin
          fx_d    = fx_cnt;
          gate_d  = gate_cnt;
          state_d = ST_MUL;
        end
      end
      ST_MUL:  state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: begin
        // Divide-by-zero ran the full length; its quotient is discarded here.
        if (div_zero || (quo[63:32] != '0)) begin
          freq_d = SAT_VAL;
          err_d  = 1'b1;
        end else begin
          freq_d = quo[31:0];
          err_d  = 1'b0;
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    ovr_d  = data_ready && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fx_q    <= '0;
      gate_q  <= '0;
      freq_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fx_q    <= fx_d;
      gate_q  <= gate_d;
      freq_q  <= freq_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  assign freq_hz    = freq_q;
  assign freq_valid = valid_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign overrun    = ovr_q;

endmodule
